// File: rtl/argo_chan_pipe.sv
// Three-stage channel pipeline: push into FIFO 1, move (+ADD_CONST) into FIFO 2,
// drain FIFO 2 into a registered output with valid/ready handshake.
module argo_chan_pipe #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 4,
   parameter int unsigned      ADDR_W    = 2,
   parameter logic [WIDTH-1:0] ADD_CONST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ivalid,
   output logic             oready,
   input  logic [WIDTH-1:0] datain,
   output logic             ovalid,
   input  logic             iready,
   output logic [WIDTH-1:0] dataout
);

   localparam logic [ADDR_W-1:0] LP_PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LP_CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   LP_FULL    = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  r_mem1 [DEPTH];
   logic [WIDTH-1:0]  r_mem2 [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr1;
   logic [ADDR_W-1:0] r_rd_ptr1;
   logic [ADDR_W-1:0] r_wr_ptr2;
   logic [ADDR_W-1:0] r_rd_ptr2;
   logic [ADDR_W:0]   r_count1;
   logic [ADDR_W:0]   r_count2;
   logic              r_ovalid;
   logic [WIDTH-1:0]  r_dataout;

   logic              w_push1;
   logic              w_move;
   logic              w_load;
   logic [WIDTH-1:0]  w_head1;
   logic [WIDTH-1:0]  w_head2;
   logic [WIDTH-1:0]  w_move_data;

   // oready looks at count1 only, so a pop from a full FIFO 1 frees a slot one cycle later
   assign oready      = (r_count1 != LP_FULL);
   assign w_push1     = ivalid && oready;
   assign w_move      = (r_count1 != '0) && (r_count2 != LP_FULL);
   assign w_load      = (r_count2 != '0) && (!r_ovalid || iready);
   assign w_head1     = r_mem1[r_rd_ptr1];
   assign w_head2     = r_mem2[r_rd_ptr2];
   assign w_move_data = w_head1 + ADD_CONST;

   assign ovalid  = r_ovalid;
   assign dataout = r_dataout;

   // Storage is intentionally left uninitialised; pointers/counts gate every read.
   always_ff @(posedge clk) begin
      if (w_push1) r_mem1[r_wr_ptr1] <= datain;
      if (w_move)  r_mem2[r_wr_ptr2] <= w_move_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr1 <= '0;
         r_rd_ptr1 <= '0;
         r_wr_ptr2 <= '0;
         r_rd_ptr2 <= '0;
         r_count1  <= '0;
         r_count2  <= '0;
         r_ovalid  <= 1'b0;
         r_dataout <= '0;
      end else begin
         if (w_push1) r_wr_ptr1 <= r_wr_ptr1 + LP_PTR_ONE;
         if (w_move) begin
            r_rd_ptr1 <= r_rd_ptr1 + LP_PTR_ONE;
            r_wr_ptr2 <= r_wr_ptr2 + LP_PTR_ONE;
         end
         if (w_load) r_rd_ptr2 <= r_rd_ptr2 + LP_PTR_ONE;

         if (w_push1 && !w_move)      r_count1 <= r_count1 + LP_CNT_ONE;
         else if (!w_push1 && w_move) r_count1 <= r_count1 - LP_CNT_ONE;

         if (w_move && !w_load)      r_count2 <= r_count2 + LP_CNT_ONE;
         else if (!w_move && w_load) r_count2 <= r_count2 - LP_CNT_ONE;

         // Without a load, a consumed word can only mean FIFO 2 was empty.
         if (w_load) begin
            r_dataout <= w_head2;
            r_ovalid  <= 1'b1;
         end else if (iready) begin
            r_ovalid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_argo_chan_pipe.sv
// Scoreboard bench for argo_chan_pipe: two instances (ADD_CONST=1 and 0) share stimulus,
// acceptances push expected words, a monitor pops and compares on each consumption.
module tb_argo_chan_pipe;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         ivalid;
   logic         iready;
   logic [W-1:0] datain;
   logic         oready1, ovalid1, oready0, ovalid0;
   logic [W-1:0] dataout1, dataout0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_deliv1 = 0;
   int n_deliv0 = 0;
   bit chk_lat  = 1'b0;

   logic [W-1:0] q1 [$];
   logic [W-1:0] q0 [$];
   int           qa1 [$];
   int           qc1 [$];

   logic [W-1:0] exp1, exp0;
   int           acc1;

   argo_chan_pipe #(.WIDTH(32), .DEPTH(4), .ADDR_W(2), .ADD_CONST(32'd1)) u_dut1 (
      .clk(clk), .rst(rst), .ivalid(ivalid), .oready(oready1), .datain(datain),
      .ovalid(ovalid1), .iready(iready), .dataout(dataout1));

   argo_chan_pipe #(.WIDTH(32), .DEPTH(4), .ADDR_W(2), .ADD_CONST(32'd0)) u_dut0 (
      .clk(clk), .rst(rst), .ivalid(ivalid), .oready(oready0), .datain(datain),
      .ovalid(ovalid0), .iready(iready), .dataout(dataout0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_deliv(input int target, input int budget, input string name);
      int b;
      b = budget;
      while (n_deliv1 < target && b > 0) begin
         tick();
         b--;
      end
      chk(name, 32'(n_deliv1), 32'(target));
   endtask

   // Sampled at negedge: values seen here are those in effect at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         if (ovalid1 && iready) begin
            if (q1.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL dut1_extra_word: got 0x%08h expected no word", dataout1);
            end else begin
               exp1 = q1.pop_front();
               acc1 = qa1.pop_front();
               chk("dut1_data", dataout1, exp1);
               if (chk_lat) chk("dut1_latency", 32'(cyc + 1 - acc1), 32'd3);
            end
            qc1.push_back(cyc + 1);
            n_deliv1++;
         end
         if (ovalid0 && iready) begin
            if (q0.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL dut0_extra_word: got 0x%08h expected no word", dataout0);
            end else begin
               exp0 = q0.pop_front();
               chk("dut0_data", dataout0, exp0);
            end
            n_deliv0++;
         end
         if (ivalid && oready1) begin
            q1.push_back(datain + 32'd1);
            qa1.push_back(cyc + 1);
         end
         if (ivalid && oready0) q0.push_back(datain);
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, acc, base, b2;
      bit ok;

      rst = 1'b0; ivalid = 1'b0; iready = 1'b1; datain = '0;
      #3;
      chk("rst_ovalid1",  32'(ovalid1), 32'd0);
      chk("rst_dataout1", dataout1,     32'd0);
      chk("rst_oready1",  32'(oready1), 32'd1);
      chk("rst_ovalid0",  32'(ovalid0), 32'd0);
      chk("rst_oready0",  32'(oready0), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();

      // basic: two back-to-back words, 3-edge latency
      chk_lat = 1'b1;
      ivalid = 1'b1; datain = 32'h25;
      tick();
      datain = 32'h55;
      tick();
      ivalid = 1'b0;
      chk("basic_ovalid_early", 32'(ovalid1), 32'd0);
      tick();
      chk("basic_ovalid_w0", 32'(ovalid1), 32'd1);
      chk("basic_data_w0",   dataout1,     32'h26);
      tick();
      chk("basic_ovalid_w1", 32'(ovalid1), 32'd1);
      chk("basic_data_w1",   dataout1,     32'h56);
      chk("basic_data0_w1",  dataout0,     32'h55);
      tick();
      chk("basic_ovalid_end", 32'(ovalid1), 32'd0);
      chk("basic_data_hold",  dataout1,     32'h56);

      // backpressure until full
      chk_lat = 1'b0;
      iready = 1'b0; k = 1; acc = 0;
      for (int c = 0; c < 16; c++) begin
         ivalid = (k <= 12);
         datain = k;
         @(negedge clk);
         ok = oready1 && ivalid;
         tick();
         if (ok) begin
            acc++;
            k++;
         end
      end
      ivalid = 1'b0;
      chk("bp_accepted",  32'(acc),     32'd9);
      chk("bp_oready",    32'(oready1), 32'd0);
      chk("bp_ovalid",    32'(ovalid1), 32'd1);
      chk("bp_dataout1",  dataout1,     32'd2);
      chk("bp_dataout0",  dataout0,     32'd1);

      iready = 1'b1;
      base = n_deliv1;
      tick();
      chk("bp_oready_first_edge", 32'(oready1), 32'd0);
      tick();
      chk("bp_oready_after_pop", 32'(oready1), 32'd1);
      for (int c = 0; c < 7; c++) tick();
      chk("bp_ovalid_drained", 32'(ovalid1), 32'd0);
      chk("bp_delivered", 32'(n_deliv1 - base), 32'd9);
      if (qc1.size() >= 9) chk("bp_no_bubbles", 32'(qc1[$] - qc1[$-8]), 32'd8);
      else chk("bp_deliv_log", 32'(qc1.size()), 32'd9);

      // streaming with pointer wrap
      chk_lat = 1'b1;
      base = n_deliv1;
      for (int i = 0; i < 20; i++) begin
         ivalid = 1'b1;
         datain = i;
         @(negedge clk);
         chk("stream_oready", 32'(oready1), 32'd1);
         tick();
      end
      ivalid = 1'b0;
      wait_deliv(base + 20, 12, "stream_count");
      b2 = qc1.size();
      if (b2 >= 20) chk("stream_no_bubbles", 32'(qc1[$] - qc1[$-19]), 32'd19);
      else chk("stream_deliv_log", 32'(b2), 32'd20);

      // arithmetic wrap
      base = n_deliv1;
      ivalid = 1'b1; datain = 32'hFFFF_FFFF;
      tick();
      ivalid = 1'b0;
      wait_deliv(base + 1, 8, "arith_count");
      chk("arith_dataout1", dataout1, 32'h0000_0000);
      chk("arith_dataout0", dataout0, 32'hFFFF_FFFF);

      // output hold under toggling iready
      chk_lat = 1'b0;
      iready = 1'b0;
      ivalid = 1'b1; datain = 32'h10;
      tick();
      datain = 32'h20;
      tick();
      ivalid = 1'b0;
      tick(); tick(); tick();
      chk("hold_ovalid",  32'(ovalid1), 32'd1);
      chk("hold_first",   dataout1,     32'h11);
      iready = 1'b1;
      tick();
      chk("hold_after_r1", dataout1, 32'h21);
      iready = 1'b0;
      tick();
      chk("hold_after_r0a", dataout1, 32'h21);
      chk("hold_ovalid_r0", 32'(ovalid1), 32'd1);
      tick();
      chk("hold_after_r0b", dataout1, 32'h21);
      iready = 1'b1;
      tick();
      chk("hold_final_ovalid", 32'(ovalid1), 32'd0);
      chk("hold_final_data",   dataout1,     32'h21);

      // reset with words in flight
      iready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ivalid = 1'b1;
         datain = 32'h31 + i;
         tick();
      end
      ivalid = 1'b0;
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_ovalid1",  32'(ovalid1), 32'd0);
      chk("midrst_dataout1", dataout1,     32'd0);
      chk("midrst_oready1",  32'(oready1), 32'd1);
      chk("midrst_ovalid0",  32'(ovalid0), 32'd0);
      q1.delete(); qa1.delete(); q0.delete();
      #2;
      rst = 1'b1;
      iready = 1'b1;
      tick();
      chk_lat = 1'b1;
      base = n_deliv1;
      b2 = n_deliv0;
      ivalid = 1'b1; datain = 32'h7;
      tick();
      ivalid = 1'b0;
      wait_deliv(base + 1, 8, "midrst_count");
      tick(); tick(); tick(); tick();
      chk("midrst_only_one",   32'(n_deliv1 - base), 32'd1);
      chk("midrst_only_one0",  32'(n_deliv0 - b2),   32'd1);
      chk("midrst_dataout1",   dataout1,             32'h8);
      chk("midrst_dataout0",   dataout0,             32'h7);
      chk("midrst_idle",       32'(ovalid1),         32'd0);
      chk("end_queue1_empty",  32'(q1.size()),       32'd0);
      chk("end_queue0_empty",  32'(q0.size()),       32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/argo_chan_pipe.md
# argo_chan_pipe

Synthesizable three-stage channel pipeline that sits behind the Avalon-style valid/ready bench interface. It models three go-routines connected by two channels: stage 1 accepts words into channel FIFO 1, stage 2 moves words from FIFO 1 into FIFO 2 with a constant added, and stage 3 drains FIFO 2 into an output register. It is the device-side end of the handshake the stage benches drive, and serves as the reference target for compiler-generated channel code.

## Interface
- WIDTH, 32, data word width
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)
- ADDR_W, 2, log2(DEPTH)
- ADD_CONST, 0, constant added by stage 2, modulo 2^WIDTH

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ivalid  in  1  upstream word valid
- oready  out  1  block can accept a word this cycle
- datain  in  WIDTH  upstream word
- ovalid  out  1  dataout holds a valid word
- iready  in  1  downstream accepts the word this cycle
- dataout  out  WIDTH  output word

## Operation
- Reset (rst=0, immediate, no clock needed): FIFO pointers and counts = 0, ovalid=0, dataout=0, oready=1 (it is derived from count1). FIFO storage is not cleared.
- Stage 1 (push): oready = (count1 != DEPTH). On an edge with ivalid && oready, datain is written at wr_ptr1; wr_ptr1 advances.
- Stage 2 (move): on an edge with count1 != 0 && count2 != DEPTH, the FIFO 1 head is popped and head+ADD_CONST (truncated to WIDTH) is written into FIFO 2.
- Stage 3 (output register): load = (count2 != 0) && (!ovalid || iready). On load, dataout gets the FIFO 2 head, ovalid=1, FIFO 2 is popped. If ovalid && iready && count2==0, then ovalid drops to 0 and dataout holds its value. If ovalid && !iready, dataout and ovalid hold.
- Pointers are ADDR_W bits and wrap naturally. Counts are ADDR_W+1 bits.
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- oready uses count1 only. A same-cycle pop from a full FIFO 1 does not raise oready in that cycle.
- There is no bypass. A word written into an empty FIFO is not readable until the next edge.
- Order is preserved end to end. No word is dropped or duplicated.
- Words with ivalid=1 while oready=0 are ignored. Upstream must hold the word.

## Timing
- Latency: a word accepted on edge T is in FIFO 2 after edge T+1 and is on dataout with ovalid=1 after edge T+2. That is 3 edges from acceptance to consumption at iready=1.
- Throughput: 1 word per cycle sustained when iready=1.
- Capacity: 2*DEPTH+1 words (9 at DEPTH=4) before oready falls.
- Recovery from full: oready rises in the cycle after the first FIFO 1 pop.
- Reset mid-operation: all in-flight words are discarded. Outputs reach their reset values combinationally from the reset assertion. The first accepted word after rst deasserts behaves as in an empty pipe.

## Test plan
- Basic: ADD_CONST=1, iready=1, send 0x25 then 0x55 on consecutive edges -> dataout shows 0x26 then 0x56 on consecutive cycles, ovalid high 3 edges after each acceptance, then ovalid=0.
- Backpressure/full: DEPTH=4, iready=0, present words 1..12 continuously -> exactly 9 accepted, oready=0 from then on, dataout=1 held stable. Then set iready=1 -> 1..9 delivered one per cycle, and oready returns in the cycle after the first FIFO 1 pop.
- Wrap-around/streaming: DEPTH=4, iready=1, 20 consecutive words 0..19 -> all delivered in order at 1 per cycle with no bubbles after the initial 3-edge latency, and pointers wrap five times.
- Arithmetic wrap: ADD_CONST=1, datain=0xFFFFFFFF -> dataout=0x00000000. With ADD_CONST=0, datain=0xFFFFFFFF -> dataout=0xFFFFFFFF.
- Output hold: with ovalid=1, toggle iready 1,0,0,1 -> dataout changes only on edges where iready=1, and no word is lost or repeated.
- Reset mid-op: 5 words in flight, pull rst low between edges -> ovalid=0, dataout=0, oready=1 immediately. After release, send 0x7 -> only 0x7 (+ADD_CONST) appears, with no stale words.
